mac_operand_sequencer: RTL and testbench

- Initiator side of the multiply-accumulate compute path.
- Fetches N operand pairs from synchronous-read RAM and ROM.
- Presents each pair to the compute block with a per-operand enable and clears the accumulator before a run.
- After a fixed drain latency, captures the accumulated dot-product result and pulses done for the controller.

---
 rtl/mac_operand_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: initiator for the multiply-accumulate path.
// Streams N operand pairs from synchronous-read RAM/ROM into the compute block,
// clears the accumulator at the start of a run and captures the final sum once
// the compute pipeline has drained.
// Optional build macro: MAC_SEQ_SELFCHECK_EN adds a shadow accumulator that
// cross-checks acc_in at capture time and raises mismatch on disagreement.
module mac_operand_sequencer #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int ACC_W   = 12,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   vec_len,
  input  logic [ADDR_W-1:0] ram_base,
  input  logic [ADDR_W-1:0] rom_base,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] rom_out,
  output logic              mac_enable,
  output logic              acc_clear,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              mismatch
);

  // DRAIN spans the two operand stages plus MAC_LAT, i.e. MAC_LAT+2 cycles.
  localparam int              DRN_W    = $clog2(MAC_LAT + 2) + 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT + 1);
  localparam logic [ADDR_W:0]  ONE      = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic              vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0] ram_p2, rom_p2;
  logic              accept_run, accept_empty, drain_last;

  assign ram_out    = ram_p2;
  assign rom_out    = rom_p2;
  assign mac_enable = vld_p2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    vld_p0       = 1'b0;
    accept_run   = 1'b0;
    accept_empty = 1'b0;
    drain_last   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (vec_len != '0) begin
            accept_run = 1'b1;
            state_nxt  = ISSUE;
          end else begin
            accept_empty = 1'b1;
          end
        end
      end
      ISSUE: begin
        busy   = 1'b1;
        vld_p0 = 1'b1;
        if (cnt == n_q - ONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drn_cnt == DRN_LAST) begin
          drain_last = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: latch length and bases, step addresses, time the drain
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= '0;
      cnt      <= '0;
      drn_cnt  <= '0;
      ram_addr <= '0;
      rom_addr <= '0;
    end else begin
      if (accept_run) begin
        n_q      <= vec_len;
        cnt      <= '0;
        ram_addr <= ram_base;
        rom_addr <= rom_base;
      end else if (vld_p0) begin
        cnt      <= cnt + ONE;
        ram_addr <= ram_addr + ADDR_W'(1);
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (state == DRAIN) drn_cnt <= drn_cnt + DRN_W'(1);
      else                drn_cnt <= '0;
    end
  end

  // Operand pipeline: p0 address out, p1 memory data valid, p2 registered operands
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ram_p2 <= '0;
      rom_p2 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        ram_p2 <= ram_data;
        rom_p2 <= rom_data;
      end
    end
  end

  // Accumulator clear, done pulse and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      acc_clear <= accept_run;
      done      <= drain_last | accept_empty;
      if (drain_last)        result <= acc_in;
      else if (accept_empty) result <= '0;
    end
  end

`ifdef MAC_SEQ_SELFCHECK_EN
  logic [ACC_W-1:0] shadow;

  function automatic logic [ACC_W-1:0] acc_wrap_add(input logic [ACC_W-1:0]  acc,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return acc + ACC_W'(prod);
  endfunction

  // Shadow accumulator mirrors the compute block and is compared at capture
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      mismatch <= 1'b0;
    end else begin
      if (acc_clear)   shadow <= '0;
      else if (vld_p2) shadow <= acc_wrap_add(shadow, ram_p2, rom_p2);
      if (drain_last)        mismatch <= (shadow != acc_in);
      else if (accept_empty) mismatch <= 1'b0;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Testbench for mac_operand_sequencer: emulates the RAM/ROM and the compute
// block, and checks every cycle against a cycle-indexed model of a run.
module tb_mac_operand_sequencer;
  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int ACC_W   = 12;
  localparam int MAC_LAT = 2;
  localparam int DEPTH   = 16;
`ifdef MAC_SEQ_SELFCHECK_EN
  localparam bit SELF = 1'b1;
`else
  localparam bit SELF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   vec_len = '0;
  logic [ADDR_W-1:0] ram_base = '0, rom_base = '0;
  logic [ADDR_W-1:0] ram_addr, rom_addr;
  logic [DATA_W-1:0] ram_data = '0, rom_data = '0;
  logic [DATA_W-1:0] ram_out, rom_out;
  logic              mac_enable, acc_clear, busy, done, mismatch;
  logic [ACC_W-1:0]  acc_in = '0, acc_q = '0, result;

  int ram_mem[DEPTH];
  int rom_mem[DEPTH];
  int err_off = 0;
  int checks = 0, errors = 0;
  int done_cnt = 0, en_cnt = 0;

  mac_operand_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .ram_base(ram_base), .rom_base(rom_base),
    .ram_addr(ram_addr), .rom_addr(rom_addr),
    .ram_data(ram_data), .rom_data(rom_data),
    .ram_out(ram_out), .rom_out(rom_out),
    .mac_enable(mac_enable), .acc_clear(acc_clear), .acc_in(acc_in),
    .busy(busy), .done(done), .result(result), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    ram_data <= DATA_W'(ram_mem[ram_addr]);
    rom_data <= DATA_W'(rom_mem[rom_addr]);
  end

  // Compute block: accumulator plus one output register gives MAC_LAT = 2
  always @(posedge clk) begin
    if (acc_clear)       acc_q <= '0;
    else if (mac_enable) acc_q <= acc_q + ACC_W'(ram_out) * ACC_W'(rom_out);
    acc_in <= acc_q + ACC_W'(err_off);
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int dot(input int n, input int rb, input int ob, input int err);
    int s = 0;
    for (int k = 0; k < n; k++) s += ram_mem[(rb + k) % DEPTH] * rom_mem[(ob + k) % DEPTH];
    return (s + err) % (1 << ACC_W);
  endfunction

  // Reference model: one run record, outputs derived from the cycle index j
  // relative to the edge at which start was accepted.
  int cyc = 0;
  bit run_active = 0, in_rst = 0;
  int run_e = 0, run_n = 0, run_rb = 0, run_ob = 0, run_err = 0, exp_res = 0;
  bit exp_busy = 0, exp_clr = 0, exp_en = 0, exp_done = 0, chk_addr = 0;
  int exp_ra = 0, exp_oa = 0, held_res = 0, held_mis = 0, held_a = 0, held_b = 0;

  always @(posedge clk) begin
    int j;
    bit idle;
    cyc++;
    if (rst) begin
      run_active = 0; in_rst = 1;
      exp_busy = 0; exp_clr = 0; exp_en = 0; exp_done = 0; chk_addr = 0;
      held_res = 0; held_mis = 0; held_a = 0; held_b = 0;
    end else begin
      in_rst = 0;
      idle = !run_active || run_n == 0 || (cyc - run_e) > 3 + run_n + MAC_LAT;
      if (start && idle) begin
        run_active = 1; run_e = cyc; run_n = int'(vec_len);
        run_rb = int'(ram_base); run_ob = int'(rom_base);
        run_err = (run_n > 0) ? err_off : 0;
        exp_res = (run_n > 0) ? dot(run_n, run_rb, run_ob, run_err) : 0;
      end
      j = cyc - run_e + 1;
      exp_busy = run_active && run_n > 0 && j >= 1 && j <= 3 + run_n + MAC_LAT;
      exp_clr  = run_active && run_n > 0 && j == 1;
      exp_en   = run_active && run_n > 0 && j >= 3 && j <= 2 + run_n;
      chk_addr = run_active && run_n > 0 && j >= 1 && j <= run_n;
      exp_ra   = (run_rb + j - 1) % DEPTH;
      exp_oa   = (run_ob + j - 1) % DEPTH;
      exp_done = run_active && j == ((run_n == 0) ? 1 : 3 + run_n + MAC_LAT);
      if (exp_en) begin
        held_a = ram_mem[(run_rb + j - 3) % DEPTH];
        held_b = rom_mem[(run_ob + j - 3) % DEPTH];
      end
      if (exp_done) begin
        held_res = exp_res;
        held_mis = (SELF && run_n > 0 && (run_err % (1 << ACC_W)) != 0) ? 1 : 0;
      end
    end
  end

  // Per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("acc_clear", int'(acc_clear), int'(exp_clr));
      chk("mac_enable", int'(mac_enable), int'(exp_en));
      chk("done", int'(done), int'(exp_done));
      chk("result", int'(result), held_res);
      chk("mismatch", int'(mismatch), held_mis);
      chk("ram_out", int'(ram_out), held_a);
      chk("rom_out", int'(rom_out), held_b);
      if (chk_addr) begin
        chk("ram_addr", int'(ram_addr), exp_ra);
        chk("rom_addr", int'(rom_addr), exp_oa);
      end
      if (in_rst) begin
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
      end
      if (done) done_cnt++;
      if (mac_enable) en_cnt++;
    end
  end

  task automatic kick(input int n, input int rb, input int ob);
    @(negedge clk);
    vec_len  = (ADDR_W + 1)'(n);
    ram_base = ADDR_W'(rb);
    rom_base = ADDR_W'(ob);
    start    = 1'b1;
  endtask

  task automatic wait_done(input bit noise, input int i0, output int lat);
    lat = 0;
    for (int i = i0 + 1; i <= i0 + 120; i++) begin
      @(negedge clk);
      if (noise) begin
        start    = 1'($urandom);
        vec_len  = (ADDR_W + 1)'($urandom);
        ram_base = ADDR_W'($urandom);
        rom_base = ADDR_W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL wait_done actual=no_done required=done_within_120_cycles");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat, e0, d0;
    int ra[4];
    int oa[4];
    for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = 0; rom_mem[i] = 0; end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);

    // Basic dot product 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin ram_mem[i] = i + 1; rom_mem[i] = i + 5; end
    kick(4, 0, 0);
    e0 = en_cnt;
    wait_done(1'b0, 0, lat);
    chk("t1_latency", lat, 9);
    chk("t1_result", int'(result), 70);
    chk("t1_model", exp_res, 70);
    chk("t1_enables", en_cnt - e0, 4);
    repeat (2) @(negedge clk);

    // Full-length run, all operands 15: 16*225 = 3600
    for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = 15; rom_mem[i] = 15; end
    kick(16, 0, 0);
    e0 = en_cnt;
    wait_done(1'b0, 0, lat);
    chk("t2_latency", lat, 21);
    chk("t2_result", int'(result), 3600);
    chk("t2_enables", en_cnt - e0, 16);
    chk("t2_mismatch", int'(mismatch), 0);
    repeat (2) @(negedge clk);

    // Address wrap
    for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = $urandom_range(0, 15); rom_mem[i] = $urandom_range(0, 15); end
    kick(4, 14, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      ra[i] = int'(ram_addr);
      oa[i] = int'(rom_addr);
    end
    wait_done(1'b0, 4, lat);
    chk("t3_ra0", ra[0], 14); chk("t3_ra1", ra[1], 15);
    chk("t3_ra2", ra[2], 0);  chk("t3_ra3", ra[3], 1);
    chk("t3_oa0", oa[0], 2);  chk("t3_oa3", oa[3], 5);
    chk("t3_result", int'(result), dot(4, 14, 2, 0));
    repeat (2) @(negedge clk);

    // Empty run
    kick(0, 5, 5);
    wait_done(1'b0, 0, lat);
    chk("t4_latency", lat, 1);
    chk("t4_result", int'(result), 0);
    repeat (2) @(negedge clk);

    // Start noise during a run yields exactly one done
    d0 = done_cnt;
    kick(4, 1, 7);
    wait_done(1'b1, 0, lat);
    repeat (20) @(negedge clk);
    chk("t5_single_done", done_cnt - d0, 1);

    // Reset in the middle of an N=8 run
    d0 = done_cnt;
    kick(8, 0, 0);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_result", int'(result), 0);
    chk("t6_enable", int'(mac_enable), 0);
    repeat (20) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    kick(5, 3, 9);
    wait_done(1'b0, 0, lat);
    chk("t6_rerun_latency", lat, 10);
    chk("t6_rerun_result", int'(result), dot(5, 3, 9, 0));
    repeat (2) @(negedge clk);

    // Accumulator deliberately off by one, then a clean run
    for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = 0; rom_mem[i] = 0; end
    for (int i = 0; i < 4; i++) begin ram_mem[i] = i + 1; rom_mem[i] = i + 5; end
    err_off = 1;
    kick(4, 0, 0);
    wait_done(1'b0, 0, lat);
    chk("t7_result_err", int'(result), 71);
`ifdef MAC_SEQ_SELFCHECK_EN
    chk("t7_mismatch_err", int'(mismatch), 1);
`else
    chk("t7_mismatch_err", int'(mismatch), 0);
`endif
    repeat (2) @(negedge clk);
    err_off = 0;
    kick(4, 0, 0);
    wait_done(1'b0, 0, lat);
    chk("t7_result_ok", int'(result), 70);
    chk("t7_mismatch_ok", int'(mismatch), 0);
    repeat (2) @(negedge clk);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int n;
      bit noise;
      for (int i = 0; i < DEPTH; i++) begin ram_mem[i] = $urandom_range(0, 15); rom_mem[i] = $urandom_range(0, 15); end
      err_off = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      n = $urandom_range(0, 16);
      noise = (n > 0) && ($urandom_range(0, 1) == 1);
      kick(n, $urandom_range(0, 15), $urandom_range(0, 15));
      wait_done(noise, 0, lat);
      chk("rand_latency", lat, (n == 0) ? 1 : 3 + n + MAC_LAT);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
